cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
// Sits between the cpu's I-cache and D-cache miss ports and the single shared
// cacheline memory port, downstream of both caches. Serialises whole-line
// reads/writebacks from the two caches onto memory, one transaction at a time.
// Arbitrates round-robin and holds every memory-side request stable until
// mem_resp.
// PARAMETERS
// LINE_WIDTH   256  bits per cacheline transfer
// ADDR_WIDTH   32   line address width (low log2(LINE_WIDTH/8) bits are zero)
// PORTS
// clk            in   1           clock, all state on rising edge
// rst            in   1           asynchronous, active-high reset
// i_pmem_read    in   1           I-cache line read request, level, held until i_pmem_resp
// i_pmem_address in   ADDR_WIDTH  I-cache line address
// i_pmem_rdata   out  LINE_WIDTH  line data to I-cache, valid when i_pmem_resp
// i_pmem_resp    out  1           one-cycle completion pulse to I-cache
// d_pmem_read    in   1           D-cache line read request, level
// d_pmem_write   in   1           D-cache writeback request, level
// d_pmem_address in   ADDR_WIDTH  D-cache line address
// d_pmem_wdata   in   LINE_WIDTH  D-cache writeback data
// d_pmem_rdata   out  LINE_WIDTH  line data to D-cache, valid when d_pmem_resp
// d_pmem_resp    out  1           one-cycle completion pulse to D-cache
// mem_read       out  1           memory read, held until mem_resp
// mem_write      out  1           memory write, held until mem_resp
// mem_address    out  ADDR_WIDTH  latched address of granted request
// mem_wdata      out  LINE_WIDTH  latched write data (D writes only)
// mem_rdata      in   LINE_WIDTH  memory read data, valid with mem_resp
// mem_resp       in   1           one-cycle completion pulse from memory
// BEHAVIOUR
// - States: IDLE, SERVE_I, SERVE_D, RECOVER. Reset -> IDLE, last_grant=I.
// - Reset values: all outputs 0, latched address/wdata 0.
//   Reset mid-transaction returns to IDLE immediately, with no resp issued.
// - IDLE: sample requests.
//   - I only -> SERVE_I. D (read or write) only -> SERVE_D.
//   - Both -> grant the side not in last_grant.
//   - On grant, latch address, op and wdata; update last_grant. None -> stay.
// - SERVE_x: mem_read/mem_write driven from the latched op. Asserted from the
//   cycle after the grant, constant until mem_resp.
// - On mem_resp in SERVE_x:
//   - Pulse the granted side's *_resp in the same cycle.
//   - *_rdata = mem_rdata combinationally; the other side's rdata/resp stay 0.
//   - Then go to RECOVER.
// - RECOVER: one cycle; all mem_* requests low, so requesters can drop their
//   level request. Then go to IDLE.
// - Latency: request at cycle 0 -> mem_* high at cycle 1. mem_resp at N ->
//   requester resp at N, earliest next mem_* at N+3.
// - d_pmem_read && d_pmem_write together: treated as write (mem_write only).
// - Requester dropping its request mid-SERVE: the transaction still completes.
//   The resp pulse is still issued. No abort on the memory side.
// - mem_read and mem_write are never high together. mem_resp outside SERVE_x
//   is ignored.
// - Request inputs are not latched while busy; a requester must hold its level.
// TESTING
// - Reset mid-SERVE_D write: rst at cycle 3 -> mem_write=0 that cycle, no
//   d_pmem_resp, state IDLE.
// - I read alone, addr 0x0000_1040, mem_resp after 5 cycles with
//   rdata=0xA5..A5 -> mem_read high cycles 1-5. i_pmem_resp=1 at cycle 5 with
//   rdata 0xA5..A5; d_pmem_resp stays 0.
// - D write alone, addr 0x0000_2080, wdata=0x1234..: mem_write=1 with
//   mem_address=0x2080 and mem_wdata stable until mem_resp, then d_pmem_resp
//   pulses for 1 cycle.
// - I and D requests together from reset (last_grant=I) -> D served first.
//   I served next, mem_read reasserts 3 cycles after the D resp.
// - Back-to-back: I re-requests after each resp while D stays high ->
//   grants alternate I,D,I,D; neither side starves.
// - D asserts read+write together, addr 0x40 -> mem_write=1 and mem_read=0
//   throughout.

Source files
------------

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache line transfers onto one memory port.
// One transaction in flight; memory-side request held from grant until mem_resp.
module cache_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  last_d_q;   // 1 when the most recent grant went to the D side
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  d_req;
  logic                  grant_i, grant_d;
  logic                  serving;

  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pmem_read && d_req) begin
          grant_i = last_d_q;
          grant_d = ~last_d_q;
        end else begin
          grant_i = i_pmem_read;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_d = SERVE_I;
        end else if (grant_d) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      op_write_q <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        last_d_q   <= 1'b0;
        op_write_q <= 1'b0;
        address_q  <= i_pmem_address;
      end else if (grant_d) begin
        // A simultaneous read+write from the D side is a writeback.
        last_d_q   <= 1'b1;
        op_write_q <= d_pmem_write;
        address_q  <= d_pmem_address;
        if (d_pmem_write) begin
          wdata_q <= d_pmem_wdata;
        end
      end
    end
  end

  assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign mem_read    = serving & ~op_write_q;
  assign mem_write   = serving & op_write_q;
  assign mem_address = address_q;
  assign mem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios then randomized transactions, each
// checked against a transaction-level round-robin model.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_rd = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wd = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata = '0;
  logic          m_resp = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  bit model_last_d = 1'b0;  // side that received the previous grant (1 = D)

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_rd), .i_pmem_address(i_addr), .i_pmem_rdata(i_rdata),
    .i_pmem_resp(i_resp),
    .d_pmem_read(d_rd), .d_pmem_write(d_wr), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wd), .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
    .mem_read(m_read), .mem_write(m_write), .mem_address(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata), .mem_resp(m_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom) & ~AW'(31);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with requests already driven; runs one whole transaction.
  task automatic run_txn(input int lat, input logic [LW-1:0] rd, input bit drop);
    bit            win_d, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wd;
    bit            last_beat;
    if (i_rd && (d_rd || d_wr)) win_d = !model_last_d;
    else                        win_d = d_rd || d_wr;
    model_last_d = win_d;
    exp_wr   = win_d && d_wr;
    exp_addr = win_d ? d_addr : i_addr;
    exp_wd   = d_wd;
    @(negedge clk);
    check("idle_mem_read", LW'(m_read), LW'(0));
    check("idle_mem_write", LW'(m_write), LW'(0));
    next_cycle();
    for (int k = 1; k <= lat; k++) begin
      last_beat = (k == lat);
      if (last_beat) begin
        m_resp  = 1'b1;
        m_rdata = rd;
      end
      if (k == 2) begin
        // Inputs may wander once granted; the memory side must hold the latched values.
        i_addr = rand_addr();
        d_addr = rand_addr();
        d_wd   = rand_line();
        if (drop) begin
          if (win_d) begin d_rd = 1'b0; d_wr = 1'b0; end
          else i_rd = 1'b0;
        end
      end
      @(negedge clk);
      check("serve_mem_read", LW'(m_read), LW'(!exp_wr));
      check("serve_mem_write", LW'(m_write), LW'(exp_wr));
      check("serve_mem_address", LW'(m_addr), LW'(exp_addr));
      if (exp_wr) check("serve_mem_wdata", m_wdata, exp_wd);
      check("i_resp", LW'(i_resp), LW'(last_beat && !win_d));
      check("d_resp", LW'(d_resp), LW'(last_beat && win_d));
      check("i_rdata", i_rdata, (last_beat && !win_d) ? rd : '0);
      check("d_rdata", d_rdata, (last_beat && win_d) ? rd : '0);
      next_cycle();
    end
    // Recovery cycle: stray mem_resp must be ignored.
    m_resp  = 1'b1;
    m_rdata = rand_line();
    if (win_d) begin d_rd = 1'b0; d_wr = 1'b0; end
    else i_rd = 1'b0;
    @(negedge clk);
    check("recover_mem_read", LW'(m_read), LW'(0));
    check("recover_mem_write", LW'(m_write), LW'(0));
    check("recover_i_resp", LW'(i_resp), LW'(0));
    check("recover_d_resp", LW'(d_resp), LW'(0));
    next_cycle();
    m_resp = 1'b0;
  endtask

  initial begin
    m_resp  = 1'b1;
    m_rdata = rand_line();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", LW'(m_read), LW'(0));
    check("rst_mem_write", LW'(m_write), LW'(0));
    check("rst_mem_address", LW'(m_addr), LW'(0));
    check("rst_mem_wdata", m_wdata, '0);
    check("rst_i_resp", LW'(i_resp), LW'(0));
    check("rst_d_resp", LW'(d_resp), LW'(0));
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    m_resp = 1'b0;
    rst    = 1'b0;
    model_last_d = 1'b0;
    next_cycle();

    // I read alone.
    i_rd = 1'b1; i_addr = 32'h0000_1040;
    run_txn(5, {32{8'hA5}}, 1'b0);

    // D write alone.
    d_wr = 1'b1; d_addr = 32'h0000_2080; d_wd = {16{16'h1234}};
    run_txn(4, rand_line(), 1'b0);

    // Reset in the middle of a D write.
    d_wr = 1'b1; d_addr = 32'h0000_0300; d_wd = rand_line();
    next_cycle();
    next_cycle();
    next_cycle();
    rst    = 1'b1;
    m_resp = 1'b1;
    @(negedge clk);
    check("midrst_mem_write", LW'(m_write), LW'(0));
    check("midrst_d_resp", LW'(d_resp), LW'(0));
    check("midrst_mem_address", LW'(m_addr), LW'(0));
    check("midrst_mem_wdata", m_wdata, '0);
    d_wr   = 1'b0;
    m_resp = 1'b0;
    rst    = 1'b0;
    model_last_d = 1'b0;
    next_cycle();

    // Both from reset: D wins, then I after the recovery gap.
    i_rd = 1'b1; i_addr = 32'h0000_0500;
    d_rd = 1'b1; d_addr = 32'h0000_0600;
    run_txn(2, rand_line(), 1'b0);
    run_txn(3, rand_line(), 1'b0);

    // D read+write together is a write.
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0040; d_wd = rand_line();
    run_txn(3, rand_line(), 1'b0);

    // Back-to-back contention: both sides re-request immediately.
    for (int n = 0; n < 4; n++) begin
      if (!i_rd) begin i_rd = 1'b1; i_addr = rand_addr(); end
      if (!(d_rd || d_wr)) begin d_rd = 1'b1; d_addr = rand_addr(); end
      run_txn(1 + n, rand_line(), 1'b0);
    end

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if (!i_rd && $urandom_range(1, 0) == 1) begin
        i_rd = 1'b1; i_addr = rand_addr();
      end
      if (!(d_rd || d_wr) && $urandom_range(1, 0) == 1) begin
        case ($urandom_range(2, 0))
          0:       begin d_rd = 1'b1; d_wr = 1'b0; end
          1:       begin d_rd = 1'b0; d_wr = 1'b1; end
          default: begin d_rd = 1'b1; d_wr = 1'b1; end
        endcase
        d_addr = rand_addr();
        d_wd   = rand_line();
      end
      if (!i_rd && !(d_rd || d_wr)) begin
        i_rd = 1'b1; i_addr = rand_addr();
      end
      run_txn(int'($urandom_range(6, 1)), rand_line(), ($urandom_range(3, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
